// File: rtl/ps2_mouse_tracker_pkg.sv
// Shared definitions for the PS/2 mouse tracker: FSM states and packet header bit positions.
package ps2_mouse_tracker_pkg;

   typedef enum logic [1:0] {ST_B0, ST_B1, ST_B2, ST_B3} state_e;

   localparam int BIT_L    = 0;
   localparam int BIT_R    = 1;
   localparam int BIT_M    = 2;
   localparam int BIT_SYNC = 3;
   localparam int BIT_XSGN = 4;
   localparam int BIT_YSGN = 5;
   localparam int BIT_XOVF = 6;
   localparam int BIT_YOVF = 7;

   // Header byte minus the always-one sync bit, which carries no information once accepted.
   typedef struct packed {
      logic yovf;
      logic xovf;
      logic ysgn;
      logic xsgn;
      logic m;
      logic r;
      logic l;
   } hdr_t;

   function automatic hdr_t hdr_from_byte(input logic [7:0] b);
      hdr_t h;
      h.yovf = b[BIT_YOVF];
      h.xovf = b[BIT_XOVF];
      h.ysgn = b[BIT_YSGN];
      h.xsgn = b[BIT_XSGN];
      h.m    = b[BIT_M];
      h.r    = b[BIT_R];
      h.l    = b[BIT_L];
      return h;
   endfunction

endpackage

// File: rtl/ps2_mouse_tracker_axis_accum.sv
// One cursor axis: scales a 9-bit signed delta, adds or subtracts it, and clamps into [0,MAX].
module ps2_axis_accum #(
   parameter int POS_W = 10,
   parameter int MAX   = 639,
   parameter int INIT  = 320,
   parameter int SHIFT = 0,
   parameter int NEG   = 0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             upd_i,
   input  logic             ovf_i,
   input  logic [8:0]       delta_i,
   output logic [POS_W-1:0] pos_o
);

   // Two guard bits above the wider of position and delta so the sum never wraps.
   localparam int SW = ((POS_W > 9) ? POS_W : 9) + 2;
   localparam logic signed [SW-1:0] MAX_S  = SW'(MAX);
   localparam logic [POS_W-1:0]     MAX_P  = POS_W'(MAX);
   localparam logic [POS_W-1:0]     INIT_P = POS_W'(INIT);

   logic [POS_W-1:0]     pos_q, pos_d;
   logic signed [8:0]    d, ds;
   logic signed [SW-1:0] pos_ext, ds_ext, sum;

   always_comb begin
      d       = ovf_i ? 9'sd0 : $signed(delta_i);
      ds      = d >>> SHIFT;
      ds_ext  = {{(SW-9){ds[8]}}, ds};
      pos_ext = $signed({{(SW-POS_W){1'b0}}, pos_q});
      sum     = (NEG != 0) ? (pos_ext - ds_ext) : (pos_ext + ds_ext);
      pos_d   = pos_q;
      if (upd_i) begin
         if (sum[SW-1])
            pos_d = '0;
         else if (sum > MAX_S)
            pos_d = MAX_P;
         else
            pos_d = sum[POS_W-1:0];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) pos_q <= INIT_P;
      else       pos_q <= pos_d;
   end

   assign pos_o = pos_q;

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse packet framer and cursor tracker: frames 3/4-byte packets with resync and
// inter-byte timeout, then drives clamped position, button levels, clicks and wheel steps.
module ps2_mouse_tracker #(
   parameter int POS_W    = 10,
   parameter int X_MAX    = 639,
   parameter int Y_MAX    = 479,
   parameter int X_INIT   = 320,
   parameter int Y_INIT   = 240,
   parameter int WHEEL_EN = 0,
   parameter int SHIFT    = 0,
   parameter int Y_INVERT = 1,
   parameter int TIMEOUT  = 200000
) (
   input  logic             sys_clk,
   input  logic             reset,
   input  logic [7:0]       rx_byte,
   input  logic             rx_valid,
   input  logic             rx_err,
   output logic [POS_W-1:0] pos_x,
   output logic [POS_W-1:0] pos_y,
   output logic             btn_left,
   output logic             btn_right,
   output logic             btn_middle,
   output logic             left_click,
   output logic             right_click,
   output logic [3:0]       wheel_delta,
   output logic             wheel_step,
   output logic             pkt_valid,
   output logic             sync_err
);
   import ps2_mouse_tracker_pkg::*;

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   state_e        state_q, state_d;
   hdr_t          hdr_q, hdr_d;
   logic [7:0]    b1_q, b1_d, b2_q, b2_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          commit, drop;

   logic [2:0]    btn_q;
   logic          lclk_q, rclk_q, wstep_q, pkt_q, serr_q;
   logic [3:0]    wdelta_q;

   logic [7:0]    b2_eff;
   logic [3:0]    z;

   // Framing FSM; rx_err beats rx_valid, and the timer only runs mid-packet while idle.
   always_comb begin
      state_d = state_q;
      hdr_d   = hdr_q;
      b1_d    = b1_q;
      b2_d    = b2_q;
      timer_d = '0;
      commit  = 1'b0;
      drop    = 1'b0;
      if (rx_err) begin
         state_d = ST_B0;
         drop    = 1'b1;
      end else begin
         case (state_q)
            ST_B0: if (rx_valid) begin
               if (rx_byte[BIT_SYNC]) begin
                  hdr_d   = hdr_from_byte(rx_byte);
                  state_d = ST_B1;
               end else begin
                  drop = 1'b1;
               end
            end
            ST_B1: if (rx_valid) begin
               b1_d    = rx_byte;
               state_d = ST_B2;
            end
            ST_B2: if (rx_valid) begin
               b2_d = rx_byte;
               if (WHEEL_EN != 0) begin
                  state_d = ST_B3;
               end else begin
                  state_d = ST_B0;
                  commit  = 1'b1;
               end
            end
            ST_B3: if (rx_valid) begin
               state_d = ST_B0;
               commit  = 1'b1;
            end
            default: state_d = ST_B0;
         endcase
         if (!rx_valid && state_q != ST_B0) begin
            if (timer_q == TMO_LAST) begin
               state_d = ST_B0;
               drop    = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
      end
   end

   // The final byte is consumed straight off rx_byte on the commit edge.
   assign b2_eff = (WHEEL_EN != 0) ? b2_q : rx_byte;
   assign z      = (WHEEL_EN != 0) ? rx_byte[3:0] : 4'd0;

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_B0;
         hdr_q    <= '0;
         b1_q     <= '0;
         b2_q     <= '0;
         timer_q  <= '0;
         btn_q    <= '0;
         lclk_q   <= 1'b0;
         rclk_q   <= 1'b0;
         wstep_q  <= 1'b0;
         wdelta_q <= '0;
         pkt_q    <= 1'b0;
         serr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hdr_q   <= hdr_d;
         b1_q    <= b1_d;
         b2_q    <= b2_d;
         timer_q <= timer_d;
         pkt_q   <= commit;
         serr_q  <= drop;
         lclk_q  <= commit & hdr_q.l & ~btn_q[0];
         rclk_q  <= commit & hdr_q.r & ~btn_q[1];
         wstep_q <= commit & (z != 4'd0);
         if (commit) begin
            btn_q    <= {hdr_q.m, hdr_q.r, hdr_q.l};
            wdelta_q <= z;
         end
      end
   end

   ps2_axis_accum #(
      .POS_W(POS_W), .MAX(X_MAX), .INIT(X_INIT), .SHIFT(SHIFT), .NEG(0)
   ) u_x (
      .clk_i   (sys_clk),
      .rst_i   (reset),
      .upd_i   (commit),
      .ovf_i   (hdr_q.xovf),
      .delta_i ({hdr_q.xsgn, b1_q}),
      .pos_o   (pos_x)
   );

   ps2_axis_accum #(
      .POS_W(POS_W), .MAX(Y_MAX), .INIT(Y_INIT), .SHIFT(SHIFT), .NEG(Y_INVERT)
   ) u_y (
      .clk_i   (sys_clk),
      .rst_i   (reset),
      .upd_i   (commit),
      .ovf_i   (hdr_q.yovf),
      .delta_i ({hdr_q.ysgn, b2_eff}),
      .pos_o   (pos_y)
   );

   assign btn_left    = btn_q[0];
   assign btn_right   = btn_q[1];
   assign btn_middle  = btn_q[2];
   assign left_click  = lclk_q;
   assign right_click = rclk_q;
   assign wheel_delta = wdelta_q;
   assign wheel_step  = wstep_q;
   assign pkt_valid   = pkt_q;
   assign sync_err    = serr_q;

endmodule
